// File: rtl/dstack_pkg.sv
// Shared definitions for the data-stack control decode and the data-stack
// storage stage: movement encodings and the rotate address width.
package dstack_pkg;

  // Stack movement requested by the control decode each enabled cycle.
  localparam logic [1:0] MOV_HOLD = 2'b00;
  localparam logic [1:0] MOV_PUSH = 2'b01;
  localparam logic [1:0] MOV_POP1 = 2'b10;
  localparam logic [1:0] MOV_POP2 = 2'b11;

  // Width of rotate_addr; the stack depth must equal 2**ADDR_W.
  localparam int ADDR_W = 5;

endpackage

// File: rtl/dstack_regfile.sv
// Data-stack storage stage: a DEPTH-entry shift-register stack with a
// write port at position 0, push/pop1/pop2 shifting, a partial rotate that
// shifts only positions 1..k, occupancy tracking and sticky fault flags.
module dstack_regfile
  import dstack_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  rotate,
  input  logic [ADDR_W-1:0]     rotate_addr,
  input  logic                  clear_flags,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [CNT_W-1:0]      depth,
  output logic                  overflow,
  output logic                  underflow
);

  // Every entry is read in parallel by its neighbours, so the stack is held
  // in flops (packed) rather than in a RAM.
  logic [DEPTH-1:0][WORD_WIDTH-1:0] s_reg;
  logic [DEPTH-1:0][WORD_WIDTH-1:0] s_next;

  logic [CNT_W-1:0] depth_reg;
  logic [CNT_W-1:0] depth_next;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             overflow_event;
  logic             underflow_event;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

  // Position 0 always takes the upstream-computed new top.
  assign s_next[0] = next_top;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_entry
      localparam logic [ADDR_W-1:0] POS = ADDR_W'(gi);

      logic [WORD_WIDTH-1:0] below1;
      logic [WORD_WIDTH-1:0] below2;
      logic [WORD_WIDTH-1:0] nxt;

      // Entries past the bottom of the stack read as zero when popping.
      if (gi + 1 < DEPTH) begin : g_b1
        assign below1 = s_reg[gi+1];
      end else begin : g_b1_zero
        assign below1 = '0;
      end

      if (gi + 2 < DEPTH) begin : g_b2
        assign below2 = s_reg[gi+2];
      end else begin : g_b2_zero
        assign below2 = '0;
      end

      // Per-entry next-state mux: rotate shifts only positions 1..k,
      // otherwise the movement code selects hold/push/pop1/pop2.
      always_comb begin
        nxt = s_reg[gi];
        if (rotate) begin
          if (POS <= rotate_addr) nxt = s_reg[gi-1];
        end else begin
          case (movement)
            MOV_PUSH: nxt = s_reg[gi-1];
            MOV_POP1: nxt = below1;
            MOV_POP2: nxt = below2;
            default:  nxt = s_reg[gi];
          endcase
        end
      end

      assign s_next[gi] = nxt;
    end
  endgenerate

  // Occupancy and fault-event computation for the current request.
  always_comb begin
    depth_next      = depth_reg;
    overflow_event  = 1'b0;
    underflow_event = 1'b0;
    if (rotate) begin
      underflow_event = ({1'b0, rotate_addr} >= depth_reg);
    end else begin
      case (movement)
        MOV_PUSH: begin
          if (depth_reg == FULL) overflow_event = 1'b1;
          else                   depth_next = depth_reg + ONE;
        end
        MOV_POP1: begin
          if (depth_reg < ONE) begin
            underflow_event = 1'b1;
            depth_next      = '0;
          end else begin
            depth_next = depth_reg - ONE;
          end
        end
        MOV_POP2: begin
          if (depth_reg < TWO) begin
            underflow_event = 1'b1;
            depth_next      = '0;
          end else begin
            depth_next = depth_reg - TWO;
          end
        end
        default: depth_next = depth_reg;
      endcase
    end
  end

  // Stack array update; a stall holds every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg <= '0;
    end else if (enable) begin
      s_reg <= s_next;
    end
  end

  // Depth and sticky flags; a new fault event wins over clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (enable) begin
      depth_reg     <= depth_next;
      overflow_reg  <= (overflow_reg & ~clear_flags) | overflow_event;
      underflow_reg <= (underflow_reg & ~clear_flags) | underflow_event;
    end
  end

  assign top          = s_reg[0];
  assign second       = s_reg[1];
  assign third        = s_reg[2];
  assign rotate_value = s_reg[rotate_addr];
  assign depth        = depth_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

`ifndef SYNTHESIS
  // A rotate must arrive with movement = hold; anything else is an upstream
  // protocol error (the RTL still treats it as hold).
  a_rotate_hold : assert property (@(posedge clk) disable iff (reset)
    (enable && rotate) |-> (movement == MOV_HOLD))
    else $error("dstack_regfile: rotate with non-hold movement");
`endif

endmodule
